fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/riscv_pkg.sv | 18 +
 rtl/if_id_register.sv | 34 +++
 rtl/fetch_stage.sv | 108 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV64 pipeline definitions: data width, canonical NOP and the
// instruction-fetch state encoding.
package riscv_pkg;

  localparam int XLEN = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t S_BOOT = 2'd0;
  localparam fetch_state_t S_REQ  = 2'd1;
  localparam fetch_state_t S_HOLD = 2'd2;
  localparam fetch_state_t S_DROP = 2'd3;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: write-enabled load, and a flush that squashes the
// slot to a NOP bubble while keeping the recorded PC.
module if_id_register
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            write_en,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  input  logic            valid_in,
  output logic [XLEN-1:0] pc_out,
  output logic [31:0]     instr_out,
  output logic            valid_out
);

  // Flush outranks write so a redirect kills the slot even during a stall.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_out    <= '0;
      instr_out <= NOP;
      valid_out <= 1'b0;
    end else if (flush) begin
      instr_out <= NOP;
      valid_out <= 1'b0;
    end else if (write_en) begin
      pc_out    <= pc_in;
      instr_out <= instr_in;
      valid_out <= valid_in;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, variable-latency memory handshake, stall buffer and
// branch redirect (including a late redirect while a request is in flight).
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            PC_write,
  input  logic            IFID_write,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] PC_IF_ID,
  output logic [31:0]     Instruction_IF_ID,
  output logic            valid_IF_ID
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] saved_target;
  logic [31:0]     buffer;

  logic            have_instr;
  logic [31:0]     fetched;
  logic            advance;
  logic            ifid_we;
  logic [31:0]     ifid_instr;

  assign imem_req  = (state == S_REQ) || (state == S_DROP);
  assign imem_addr = pc;

  // An available instruction with PC_write=0 is held rather than loaded,
  // otherwise the same PC would enter IF/ID twice.
  always_comb begin
    have_instr = ((state == S_REQ) && imem_ready) || (state == S_HOLD);
    fetched    = (state == S_HOLD) ? buffer : imem_rdata;
    advance    = have_instr && IFID_write && PC_write;
    ifid_we    = IFID_write && (!have_instr || PC_write);
    ifid_instr = have_instr ? fetched : NOP;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_BOOT;
      pc           <= RESET_PC;
      saved_target <= '0;
      buffer       <= '0;
    end else begin
      case (state)
        S_BOOT: state <= S_REQ;
        S_REQ: begin
          if (branch_taken) begin
            if (imem_ready) begin
              pc <= branch_target;
            end else begin
              saved_target <= branch_target;
              state        <= S_DROP;
            end
          end else if (imem_ready) begin
            if (advance) begin
              pc <= pc_plus4(pc);
            end else begin
              buffer <= imem_rdata;
              state  <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (branch_taken) begin
            pc    <= branch_target;
            state <= S_REQ;
          end else if (advance) begin
            pc    <= pc_plus4(pc);
            state <= S_REQ;
          end
        end
        S_DROP: begin
          // The wrong-path response must still be consumed before redirecting.
          if (branch_taken) saved_target <= branch_target;
          if (imem_ready) begin
            pc    <= branch_taken ? branch_target : saved_target;
            state <= S_REQ;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

  if_id_register u_if_id (
    .clk       (clk),
    .reset_n   (reset_n),
    .write_en  (ifid_we),
    .flush     (branch_taken),
    .pc_in     (pc),
    .instr_in  (ifid_instr),
    .valid_in  (have_instr),
    .pc_out    (PC_IF_ID),
    .instr_out (Instruction_IF_ID),
    .valid_out (valid_IF_ID)
  );

endmodule
